// File: rtl/hangman_game_ctrl_if.sv
// Pin-level bundle between the pad synchronizer side and the hangman sequencer.
// The master drives the pad-facing inputs; the slave (the controller) drives the status outputs.
interface hangman_game_ctrl_if #(
  parameter int WORD_LEN = 5
);
  logic [4:0]          letter_i;
  logic                submit_i;
  logic                new_game_i;
  logic                ready_o;
  logic                hit_o;
  logic                miss_o;
  logic                win_o;
  logic                lose_o;
  logic                beep_o;
  logic [WORD_LEN-1:0] reveal_mask_o;
  logic [3:0]          miss_cnt_o;

  modport master (
    output letter_i, submit_i, new_game_i,
    input  ready_o, hit_o, miss_o, win_o, lose_o, beep_o, reveal_mask_o, miss_cnt_o
  );

  modport slave (
    input  letter_i, submit_i, new_game_i,
    output ready_o, hit_o, miss_o, win_o, lose_o, beep_o, reveal_mask_o, miss_cnt_o
  );
endinterface

// File: rtl/hangman_game_ctrl.sv
// Blind-hangman game sequencer: word setup, per-position guess scan, win/loss with pin-level feedback.
// Optional hit/miss tone on beep_o is built only when HANGMAN_BEEP_EN is defined.
module hangman_game_ctrl #(
  parameter int WORD_LEN   = 5,
  parameter int MAX_MISSES = 6,
  parameter int BEEP_DIV   = 1000,
  parameter int BEEP_LEN   = 50000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  hangman_game_ctrl_if.slave   bus
);

  localparam int               IDX_W    = $clog2(WORD_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);
  localparam logic [3:0]       MISS_MAX = 4'(MAX_MISSES);

  typedef enum logic [2:0] {
    S_SETUP,
    S_PLAY,
    S_SCAN,
    S_RESOLVE,
    S_WON,
    S_LOST
  } state_e;

  // Pad synchronizers and edge detectors
  logic [4:0] letter_s1_q, letter_s2_q;
  logic       submit_s1_q, submit_s2_q, submit_prev_q, submit_edge_q;
  logic       new_game_s1_q, new_game_s2_q, new_game_prev_q, new_game_edge_q;
  logic       letter_valid;

  // Game state
  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
  logic [WORD_LEN-1:0][4:0]  word_q, word_d;
  logic [WORD_LEN-1:0]       mask_q, mask_d;
  logic [25:0]               guessed_q, guessed_d;
  logic [3:0]                miss_cnt_q, miss_cnt_d;
  logic [4:0]                guess_q, guess_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      found_q, found_d;
  logic                      hit_q, hit_d;
  logic                      miss_q, miss_d;

  // Registered status outputs
  logic ready_q, ready_d;
  logic win_q, win_d;
  logic lose_q, lose_d;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      letter_s1_q     <= '0;
      letter_s2_q     <= '0;
      submit_s1_q     <= 1'b0;
      submit_s2_q     <= 1'b0;
      submit_prev_q   <= 1'b0;
      submit_edge_q   <= 1'b0;
      new_game_s1_q   <= 1'b0;
      new_game_s2_q   <= 1'b0;
      new_game_prev_q <= 1'b0;
      new_game_edge_q <= 1'b0;
    end else begin
      // NOTE: sequential state always uses <=, so every flop samples pre-edge values and chains shift by one stage.
      letter_s1_q     <= bus.letter_i;
      letter_s2_q     <= letter_s1_q;
      submit_s1_q     <= bus.submit_i;
      submit_s2_q     <= submit_s1_q;
      submit_prev_q   <= submit_s2_q;
      submit_edge_q   <= submit_s2_q & ~submit_prev_q;
      new_game_s1_q   <= bus.new_game_i;
      new_game_s2_q   <= new_game_s1_q;
      new_game_prev_q <= new_game_s2_q;
      new_game_edge_q <= new_game_s2_q & ~new_game_prev_q;
    end
  end

  assign letter_valid = (letter_s2_q < 5'd26);

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      // NOTE: word and guessed are plain flop arrays, not RAM, so they clear with the rest and reset matches new_game.
      state_q    <= S_SETUP;
      wr_idx_q   <= '0;
      word_q     <= '0;
      mask_q     <= '0;
      guessed_q  <= '0;
      miss_cnt_q <= '0;
      guess_q    <= '0;
      idx_q      <= '0;
      found_q    <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      ready_q    <= 1'b1;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      word_q     <= word_d;
      mask_q     <= mask_d;
      guessed_q  <= guessed_d;
      miss_cnt_q <= miss_cnt_d;
      guess_q    <= guess_d;
      idx_q      <= idx_d;
      found_q    <= found_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      ready_q    <= ready_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    // NOTE: every target gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    word_d     = word_q;
    mask_d     = mask_q;
    guessed_d  = guessed_q;
    miss_cnt_d = miss_cnt_q;
    guess_d    = guess_q;
    idx_d      = idx_q;
    found_d    = found_q;
    hit_d      = hit_q;
    miss_d     = miss_q;

    if (new_game_edge_q) begin
      state_d    = S_SETUP;
      wr_idx_d   = '0;
      word_d     = '0;
      mask_d     = '0;
      guessed_d  = '0;
      miss_cnt_d = '0;
      guess_d    = '0;
      idx_d      = '0;
      found_d    = 1'b0;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_SETUP: begin
          if (submit_edge_q && letter_valid) begin
            word_d[wr_idx_q] = letter_s2_q;
            if (wr_idx_q == LAST_IDX) begin
              wr_idx_d = '0;
              state_d  = S_PLAY;
            end else begin
              wr_idx_d = wr_idx_q + IDX_W'(1);
            end
          end
        end
        S_PLAY: begin
          if (submit_edge_q && letter_valid) begin
            hit_d  = 1'b0;
            miss_d = 1'b0;
            // A repeated letter only clears the flags; it never costs a miss.
            if (!guessed_q[letter_s2_q]) begin
              guessed_d[letter_s2_q] = 1'b1;
              guess_d                = letter_s2_q;
              idx_d                  = '0;
              found_d                = 1'b0;
              state_d                = S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (word_q[idx_q] == guess_q) begin
            mask_d[idx_q] = 1'b1;
            found_d       = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_RESOLVE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_RESOLVE: begin
          if (found_q) begin
            hit_d   = 1'b1;
            state_d = (&mask_q) ? S_WON : S_PLAY;
          end else begin
            miss_d     = 1'b1;
            miss_cnt_d = (miss_cnt_q == MISS_MAX) ? miss_cnt_q : miss_cnt_q + 4'd1;
            if (miss_cnt_d == MISS_MAX) begin
              state_d = S_LOST;
              mask_d  = '1;
            end else begin
              state_d = S_PLAY;
            end
          end
        end
        S_WON, S_LOST: begin
        end
        default: state_d = S_SETUP;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they land in flops with the state.
  always_comb begin
    ready_d = (state_d == S_SETUP) || (state_d == S_PLAY);
    win_d   = (state_d == S_WON);
    lose_d  = (state_d == S_LOST);
  end

  assign bus.ready_o       = ready_q;
  assign bus.hit_o         = hit_q;
  assign bus.miss_o        = miss_q;
  assign bus.win_o         = win_q;
  assign bus.lose_o        = lose_q;
  assign bus.reveal_mask_o = mask_q;
  assign bus.miss_cnt_o    = miss_cnt_q;

`ifdef HANGMAN_BEEP_EN
  localparam int DUR_W = $clog2(4 * BEEP_LEN + 1);
  localparam int DIV_W = $clog2(2 * BEEP_DIV + 1);

  logic [DUR_W-1:0] beep_dur_q;
  logic [DIV_W-1:0] beep_div_q;
  logic [DIV_W-1:0] beep_period_q;
  logic             beep_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      beep_dur_q    <= '0;
      beep_div_q    <= '0;
      beep_period_q <= '0;
      beep_q        <= 1'b0;
    end else if (new_game_edge_q) begin
      beep_dur_q    <= '0;
      beep_div_q    <= '0;
      beep_period_q <= '0;
      beep_q        <= 1'b0;
    end else if (state_q == S_RESOLVE) begin
      // Game-ending resolves get the long tone; a miss toggles at half the hit pitch.
      beep_dur_q    <= ((state_d == S_WON) || (state_d == S_LOST)) ? DUR_W'(4 * BEEP_LEN)
                                                                   : DUR_W'(BEEP_LEN);
      beep_period_q <= found_q ? DIV_W'(BEEP_DIV) : DIV_W'(2 * BEEP_DIV);
      beep_div_q    <= '0;
      beep_q        <= 1'b1;
    end else if (beep_dur_q != '0) begin
      beep_dur_q <= beep_dur_q - DUR_W'(1);
      if (beep_div_q == beep_period_q - DIV_W'(1)) begin
        beep_div_q <= '0;
        beep_q     <= ~beep_q;
      end else begin
        beep_div_q <= beep_div_q + DIV_W'(1);
      end
      if (beep_dur_q == DUR_W'(1)) begin
        beep_q <= 1'b0;
      end
    end
  end

  assign bus.beep_o = beep_q;
`else
  assign bus.beep_o = 1'b0;
`endif

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Self-checking bench for hangman_game_ctrl: directed test-plan steps plus random games
// compared against a letter-set reference model of the game rules.
module tb_hangman_game_ctrl;
  localparam int WL = 5;
  localparam int MM = 6;
  localparam int PH_SETUP = 0;
  localparam int PH_PLAY  = 1;
  localparam int PH_WON   = 2;
  localparam int PH_LOST  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hangman_game_ctrl_if #(.WORD_LEN(WL)) bus ();

  hangman_game_ctrl #(
    .WORD_LEN  (WL),
    .MAX_MISSES(MM),
    .BEEP_DIV  (4),
    .BEEP_LEN  (20)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the secret word, the set of letters tried, revealed positions.
  int m_word[WL];
  bit m_guessed[26];
  bit m_rev[WL];
  int m_wr;
  int m_misses;
  int m_phase;
  bit m_hit;
  bit m_miss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_wr     = 0;
    m_misses = 0;
    m_phase  = PH_SETUP;
    m_hit    = 1'b0;
    m_miss   = 1'b0;
    for (int i = 0; i < WL; i++) begin
      m_word[i] = 0;
      m_rev[i]  = 1'b0;
    end
    for (int i = 0; i < 26; i++) m_guessed[i] = 1'b0;
  endfunction

  // Applies one submitted code; returns how many of the 14 observed cycles ready_o should be low.
  function automatic int model_submit(input int l);
    bit any;
    bit all;
    if (m_phase == PH_WON || m_phase == PH_LOST) return 14;
    if (l > 25) return 0;
    if (m_phase == PH_SETUP) begin
      m_word[m_wr] = l;
      m_wr++;
      if (m_wr == WL) begin
        m_wr    = 0;
        m_phase = PH_PLAY;
      end
      return 0;
    end
    m_hit  = 1'b0;
    m_miss = 1'b0;
    if (m_guessed[l]) return 0;
    m_guessed[l] = 1'b1;
    any = 1'b0;
    for (int i = 0; i < WL; i++) begin
      if (m_word[i] == l) begin
        m_rev[i] = 1'b1;
        any      = 1'b1;
      end
    end
    if (any) begin
      m_hit = 1'b1;
      all   = 1'b1;
      for (int i = 0; i < WL; i++) all = all & m_rev[i];
      if (all) m_phase = PH_WON;
    end else begin
      m_miss = 1'b1;
      m_misses++;
      if (m_misses == MM) begin
        m_phase = PH_LOST;
        for (int i = 0; i < WL; i++) m_rev[i] = 1'b1;
      end
    end
    return (m_phase == PH_PLAY) ? 6 : 11;
  endfunction

  task automatic check_outputs(input string tag);
    logic [31:0] em;
    em = '0;
    for (int i = 0; i < WL; i++) em[i] = m_rev[i];
    check({tag, " ready"}, 32'(bus.ready_o), 32'(m_phase == PH_SETUP || m_phase == PH_PLAY));
    check({tag, " hit"}, 32'(bus.hit_o), 32'(m_hit));
    check({tag, " miss"}, 32'(bus.miss_o), 32'(m_miss));
    check({tag, " win"}, 32'(bus.win_o), 32'(m_phase == PH_WON));
    check({tag, " lose"}, 32'(bus.lose_o), 32'(m_phase == PH_LOST));
    check({tag, " mask"}, 32'(bus.reveal_mask_o), em);
    check({tag, " miss_cnt"}, 32'(bus.miss_cnt_o), 32'(m_misses));
  endtask

  // Called at a falling edge; presses submit with code l and observes 14 cycles.
  task automatic press(input int l, input string tag);
    int          exp_busy;
    int          busy;
    int          first_low;
    logic [31:0] flags9;
    exp_busy       = model_submit(l);
    bus.letter_i   = 5'(l);
    bus.submit_i   = 1'b1;
    busy           = 0;
    first_low      = 0;
    flags9         = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 4) bus.submit_i = 1'b0;
      if (k == 9) flags9 = {30'd0, bus.hit_o, bus.miss_o};
      if (bus.ready_o === 1'b0) begin
        busy++;
        if (first_low == 0) first_low = k;
      end
    end
    check({tag, " busy_cycles"}, 32'(busy), 32'(exp_busy));
    if (exp_busy == 6 || exp_busy == 11) begin
      check({tag, " first_busy"}, 32'(first_low), 32'd4);
      check({tag, " flags_before_resolve"}, flags9, 32'd0);
    end
    check_outputs(tag);
  endtask

  task automatic new_game(input string tag);
    bus.new_game_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.new_game_i = 1'b0;
    repeat (4) @(negedge clk);
    model_reset();
    check_outputs(tag);
    check({tag, " beep"}, 32'(bus.beep_o), 32'd0);
  endtask

  task automatic load_word(input int w0, input int w1, input int w2, input int w3, input int w4);
    press(w0, "load0");
    press(w1, "load1");
    press(w2, "load2");
    press(w3, "load3");
    press(w4, "load4");
  endtask

  initial begin
    int l;
    int w[WL];
    rst            = 1'b1;
    bus.letter_i   = '0;
    bus.submit_i   = 1'b0;
    bus.new_game_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs("reset");
    check("reset beep", 32'(bus.beep_o), 32'd0);

    // HELLO, with an invalid code slipped into setup
    press(7, "load H");
    press(27, "setup invalid");
    press(4, "load E");
    press(11, "load L");
    press(11, "load L2");
    press(14, "load O");
    check("play ready", 32'(bus.ready_o), 32'd1);
    check("play mask", 32'(bus.reveal_mask_o), 32'b00000);

    press(11, "guess L");
    check("L hit", 32'(bus.hit_o), 32'd1);
    check("L mask", 32'(bus.reveal_mask_o), 32'b01100);
    press(25, "guess Z");
    check("Z miss_cnt", 32'(bus.miss_cnt_o), 32'd1);
    press(11, "dup L");
    press(27, "play invalid");
    press(7, "guess H");
    press(4, "guess E");
    press(14, "guess O");
    check("won win", 32'(bus.win_o), 32'd1);
    check("won mask", 32'(bus.reveal_mask_o), 32'b11111);
    press(0, "won submit");
    press(27, "won invalid");

    // Six distinct wrong letters lose the game
    new_game("ng1");
    for (int i = 0; i < WL; i++) w[i] = int'($urandom_range(0, 12));
    load_word(w[0], w[1], w[2], w[3], w[4]);
    for (int i = 0; i < MM; i++) press(13 + i, $sformatf("wrong%0d", i));
    check("lost lose", 32'(bus.lose_o), 32'd1);
    check("lost miss_cnt", 32'(bus.miss_cnt_o), 32'd6);
    check("lost mask", 32'(bus.reveal_mask_o), 32'b11111);
    press(19, "lost submit");

    // new_game and submit edges coincide while a scan is running
    new_game("ng2");
    load_word(3, 1, 4, 1, 5);
    bus.letter_i = 5'd1;
    bus.submit_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) bus.submit_i = 1'b0;
      if (k == 4) begin
        bus.letter_i   = 5'd9;
        bus.submit_i   = 1'b1;
        bus.new_game_i = 1'b1;
      end
      if (k == 6) check("abort scanning", 32'(bus.ready_o), 32'd0);
    end
    model_reset();
    check_outputs("abort");
    check("abort beep", 32'(bus.beep_o), 32'd0);
    bus.submit_i   = 1'b0;
    bus.new_game_i = 1'b0;
    repeat (8) @(negedge clk);
    check_outputs("abort settled");

    // Random games against the model
    for (int g = 0; g < 4; g++) begin
      new_game($sformatf("rng%0d", g));
      for (int i = 0; i < WL; i++) begin
        if ($urandom_range(0, 5) == 0) press(int'($urandom_range(26, 31)), $sformatf("g%0d setup bad", g));
        press(int'($urandom_range(0, 25)), $sformatf("g%0d load%0d", g, i));
      end
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 1) == 1) l = m_word[$urandom_range(0, WL - 1)];
        else l = int'($urandom_range(0, 31));
        press(l, $sformatf("g%0d guess%0d", g, n));
        if (m_phase == PH_WON || m_phase == PH_LOST) begin
          press(int'($urandom_range(0, 25)), $sformatf("g%0d post", g));
          break;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hangman_game_ctrl.md
Name: hangman_game_ctrl

Overview:
Game sequencer for the blind-hangman user project. It sits between the synchronized pad inputs and the six status pad outputs.
- Setup phase: captures a secret word one letter at a time.
- Play phase: accepts letter guesses, scans the stored word one position per cycle, and tracks revealed positions, guessed letters and the miss count.
- Outcome: declares win or loss. Feedback is fully pin-level (no display), suiting a blind player.

Parameters:
WORD_LEN, 5, number of letters in the secret word (2..16)
MAX_MISSES, 6, misses allowed before loss (1..15)
BEEP_DIV, 1000, half-period in clocks of the hit tone (used only with the optional feature)
BEEP_LEN, 50000, tone duration in clocks (used only with the optional feature)

Ports:
wb_clk_i  in  1  single system clock
wb_rst_i  in  1  asynchronous, active-high reset
letter_i  in  5  letter code, 0=A..25=Z; codes 26..31 invalid; asynchronous pads
submit_i  in  1  pad button; rising edge = enter letter
new_game_i  in  1  pad button; rising edge = abort and restart
ready_o  out  1  block accepts a submit in current state
hit_o  out  1  last resolved guess was a hit
miss_o  out  1  last resolved guess was a miss
win_o  out  1  game won
lose_o  out  1  game lost
beep_o  out  1  audio tone (optional feature)
reveal_mask_o  out  WORD_LEN  bit i = position i revealed
miss_cnt_o  out  4  current miss count

Behaviour:
- Reset (async assert, sync release): state=SETUP, wr_idx=0, word/mask/guessed/miss_cnt=0, ready_o=1, all other outputs 0.
- Input capture:
  - submit_i, new_game_i and letter_i pass through 2-flop synchronizers.
  - An edge is registered sync2 high with prev low. Pad to edge detection takes 3 clocks.
  - letter_i is sampled from its sync stage in the edge cycle.
- new_game edge, any state: next state=SETUP and all registers cleared as at reset. It has priority over a simultaneous submit edge and aborts any SCAN in progress.
- SETUP (ready_o=1):
  - Each submit edge with a valid letter writes word[wr_idx] and increments wr_idx.
  - Invalid code: ignored, wr_idx unchanged.
  - After the write with wr_idx==WORD_LEN-1: go to PLAY, wr_idx=0.
- PLAY (ready_o=1), submit edge with valid letter L:
  - guessed[L]==1 (duplicate): hit_o=miss_o=0, no count change, stay in PLAY.
  - Otherwise: guessed[L]=1, hit_o=miss_o=0, latch L, idx=0, found=0, go to SCAN.
  - Invalid code: ignored, flags unchanged.
- SCAN (ready_o=0), one position per cycle:
  - If word[idx]==L then mask[idx]=1 and found=1.
  - At idx==WORD_LEN-1 go to RESOLVE.
  - Submit edges during SCAN/RESOLVE are dropped, not queued.
- RESOLVE (ready_o=0), one cycle:
  - found: hit_o=1. Next state WON if the updated mask is all ones, else PLAY.
  - not found: miss_cnt+1, miss_o=1. Next state LOST if the new count==MAX_MISSES, else PLAY.
- Guess latency: edge cycle E; SCAN occupies E+1..E+WORD_LEN; RESOLVE at E+WORD_LEN+1; hit_o/miss_o valid from E+WORD_LEN+2.
- hit_o/miss_o hold until the next accepted guess or a new game.
- WON: win_o=1, ready_o=0, submits ignored, mask all ones.
- LOST: lose_o=1, ready_o=0, submits ignored. reveal_mask_o = full mask of all ones (word exposed).
- miss_cnt saturates at MAX_MISSES and never wraps.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
HANGMAN_BEEP_EN
- Defined:
  - On every RESOLVE, a tone starts on beep_o for BEEP_LEN clocks.
  - Hit: toggles every BEEP_DIV clocks. Miss: toggles every 2*BEEP_DIV clocks (lower pitch).
  - WON/LOST entry: tone lasts 4*BEEP_LEN clocks.
  - A new RESOLVE restarts the tone.
  - new_game or reset silences it immediately (beep_o=0).
  - Counters are sized by $clog2 of the parameters.
- Undefined: beep_o tied 0, no tone counters synthesized, other behaviour identical.

Test Plan:
- WORD_LEN=5, MAX_MISSES=6; reset, then load H,E,L,L,O (7,4,11,11,14) -> state PLAY; ready_o=1, mask=00000.
- Guess L (11) -> ready_o low for 6 cycles; hit_o=1 at E+7; reveal_mask_o=01100 (bit0=H); miss_cnt_o=0.
- Guess Z (25), then L again -> first: miss_o=1, miss_cnt_o=1; second: duplicate, hit_o=miss_o=0, miss_cnt_o stays 1, no SCAN (ready_o stays 1).
- Guess H, E, O after L -> win_o=1 after O resolves, mask=11111; further submits produce no change.
- Six distinct wrong letters -> lose_o=1 with miss_cnt_o=6, mask=11111; letter code 27 at any point -> ignored, no state change.
- new_game edge in the same cycle as a submit edge during SCAN -> SETUP next cycle, all outputs at reset values; with HANGMAN_BEEP_EN, beep_o=0 immediately.
